ex_mem_stage: RTL

EX→MEM pipeline stage directly downstream of the ALU. Captures the ALU result, overflow and zero flags with the instruction's memory/writeback controls, and buffers them in a 2-entry skid FIFO with valid/ready handshakes on both sides. The MEM stage can stall without dropping an ALU result. Signed-overflow trap handling suppresses architectural side effects of the faulting instruction.

---
 rtl/ex_mem_stage_if.sv | 62 ++++++
 rtl/ex_mem_stage.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/ex_mem_stage_if.sv
// ex_mem_stage_if
//   Bundles the EX-side input handshake, the MEM-side output handshake and
//   the overflow-trap outputs of the EX->MEM pipeline stage.
//   slave  : view used by ex_mem_stage (consumes EX inputs, drives MEM outputs)
//   master : view used by the surrounding logic / testbench
// Ports (all signals):
//   in_valid/in_ready, Result, Overflow, zero_flag, Mode, store_data, wr_reg,
//   pc_plus4, RegWrite, MemRead, MemWrite, MemtoReg, Branch, flush,
//   out_valid/out_ready, out_result, out_store_data, out_pc_plus4, out_wr_reg,
//   out_zero, out_RegWrite, out_MemRead, out_MemWrite, out_MemtoReg,
//   out_Branch, ovf_trap, ovf_epc
interface ex_mem_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] Result;
  logic [1:0]  Overflow;
  logic        zero_flag;
  logic [1:0]  Mode;
  logic [31:0] store_data;
  logic [4:0]  wr_reg;
  logic [31:0] pc_plus4;
  logic        RegWrite;
  logic        MemRead;
  logic        MemWrite;
  logic        MemtoReg;
  logic        Branch;
  logic        flush;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [31:0] out_store_data;
  logic [31:0] out_pc_plus4;
  logic [4:0]  out_wr_reg;
  logic        out_zero;
  logic        out_RegWrite;
  logic        out_MemRead;
  logic        out_MemWrite;
  logic        out_MemtoReg;
  logic        out_Branch;

  logic        ovf_trap;
  logic [31:0] ovf_epc;

  modport slave (
    input  in_valid, Result, Overflow, zero_flag, Mode, store_data, wr_reg,
           pc_plus4, RegWrite, MemRead, MemWrite, MemtoReg, Branch, flush,
           out_ready,
    output in_ready, out_valid, out_result, out_store_data, out_pc_plus4,
           out_wr_reg, out_zero, out_RegWrite, out_MemRead, out_MemWrite,
           out_MemtoReg, out_Branch, ovf_trap, ovf_epc
  );

  modport master (
    output in_valid, Result, Overflow, zero_flag, Mode, store_data, wr_reg,
           pc_plus4, RegWrite, MemRead, MemWrite, MemtoReg, Branch, flush,
           out_ready,
    input  in_ready, out_valid, out_result, out_store_data, out_pc_plus4,
           out_wr_reg, out_zero, out_RegWrite, out_MemRead, out_MemWrite,
           out_MemtoReg, out_Branch, ovf_trap, ovf_epc
  );
endinterface

// File: rtl/ex_mem_stage.sv
// ex_mem_stage
//   EX->MEM pipeline register built as a 2-entry skid FIFO. Captures the ALU
//   result/flags with the memory and writeback controls and lets the MEM
//   stage stall without losing a result.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous reset, active high
//   bus  - ex_mem_stage_if.slave (EX input handshake, MEM output handshake,
//          ovf_trap / ovf_epc)
// Build option:
//   EX_MEM_OVF_TRAP_EN - when defined, a pushed instruction with signed
//   overflow has RegWrite/MemRead/MemWrite cleared, pulses ovf_trap and
//   records its PC in ovf_epc. When undefined, Overflow is ignored and the
//   trap outputs are tied to zero.
module ex_mem_stage (
  input logic           clk,
  input logic           rst,
  ex_mem_stage_if.slave bus
);

  typedef struct packed {
    logic [31:0] result;
    logic [31:0] store_data;
    logic [31:0] pc_plus4;
    logic [4:0]  wr_reg;
    logic        zero;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        branch;
  } entry_t;

  entry_t     r_mem [2];
  logic       r_wr_ptr;
  logic       r_rd_ptr;
  logic [1:0] r_count;
  // Output holding register: keeps the last head visible when the FIFO
  // drains, which the storage array alone cannot do once rd_ptr moves on.
  entry_t     r_head;

  logic       w_in_ready;
  logic       w_out_valid;
  logic       w_push;
  logic       w_pop;
  logic       w_ovf;
  entry_t     w_entry;
  logic [1:0] w_count_next;
  logic       w_wr_next;
  logic       w_rd_next;
  entry_t     w_head_next;

  // in_ready depends on occupancy only, so there is no out_ready->in_ready path.
  assign w_in_ready  = (r_count < 2'd2);
  assign w_out_valid = (r_count != 2'd0);
  assign w_push      = bus.in_valid && w_in_ready && !bus.flush;
  assign w_pop       = w_out_valid && bus.out_ready && !bus.flush;

`ifdef EX_MEM_OVF_TRAP_EN
  // Only signed-mode overflow traps.
  assign w_ovf = bus.Overflow[0] && (bus.Mode == 2'd1);
  logic w_unused_ovf_hi;
  assign w_unused_ovf_hi = bus.Overflow[1];
`else
  assign w_ovf = 1'b0;
  logic w_unused_ovf_in;
  assign w_unused_ovf_in = ^{bus.Overflow, bus.Mode};
`endif

  always_comb begin
    w_entry.result     = bus.Result;
    w_entry.store_data = bus.store_data;
    w_entry.pc_plus4   = bus.pc_plus4;
    w_entry.wr_reg     = bus.wr_reg;
    w_entry.zero       = bus.zero_flag;
    w_entry.reg_write  = bus.RegWrite;
    w_entry.mem_read   = bus.MemRead;
    w_entry.mem_write  = bus.MemWrite;
    w_entry.mem_to_reg = bus.MemtoReg;
    w_entry.branch     = bus.Branch;
    // The faulting instruction still flows down the pipe, but with its
    // architectural side effects removed.
    if (w_ovf) begin
      w_entry.reg_write = 1'b0;
      w_entry.mem_read  = 1'b0;
      w_entry.mem_write = 1'b0;
    end
  end

  always_comb begin
    w_count_next = r_count;
    w_wr_next    = r_wr_ptr;
    w_rd_next    = r_rd_ptr;
    w_head_next  = r_head;
    if (bus.flush) begin
      w_count_next = 2'd0;
      w_wr_next    = 1'b0;
      w_rd_next    = 1'b0;
    end else begin
      w_count_next = r_count + {1'b0, w_push} - {1'b0, w_pop};
      w_wr_next    = r_wr_ptr ^ w_push;
      w_rd_next    = r_rd_ptr ^ w_pop;
      // Next head is either the entry being written into the head slot this
      // cycle (push into empty, or push+pop at count 1) or already stored.
      if (w_count_next != 2'd0) begin
        if (w_push && (r_wr_ptr == w_rd_next)) begin
          w_head_next = w_entry;
        end else begin
          w_head_next = r_mem[w_rd_next];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
      r_head   <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_entry;
      end
      r_wr_ptr <= w_wr_next;
      r_rd_ptr <= w_rd_next;
      r_count  <= w_count_next;
      r_head   <= w_head_next;
    end
  end

`ifdef EX_MEM_OVF_TRAP_EN
  logic        r_ovf_trap;
  logic [31:0] r_ovf_epc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf_trap <= 1'b0;
      r_ovf_epc  <= 32'd0;
    end else begin
      r_ovf_trap <= w_push && w_ovf;
      // Sticky: only overwritten by the next trapping push, never by flush.
      if (w_push && w_ovf) begin
        r_ovf_epc <= bus.pc_plus4 - 32'd4;
      end
    end
  end

  assign bus.ovf_trap = r_ovf_trap;
  assign bus.ovf_epc  = r_ovf_epc;
`else
  assign bus.ovf_trap = 1'b0;
  assign bus.ovf_epc  = 32'd0;
`endif

  assign bus.in_ready       = w_in_ready;
  assign bus.out_valid      = w_out_valid;
  assign bus.out_result     = r_head.result;
  assign bus.out_store_data = r_head.store_data;
  assign bus.out_pc_plus4   = r_head.pc_plus4;
  assign bus.out_wr_reg     = r_head.wr_reg;
  assign bus.out_zero       = r_head.zero;
  assign bus.out_RegWrite   = r_head.reg_write;
  assign bus.out_MemRead    = r_head.mem_read;
  assign bus.out_MemWrite   = r_head.mem_write;
  assign bus.out_MemtoReg   = r_head.mem_to_reg;
  assign bus.out_Branch     = r_head.branch;

endmodule
